spike_recorder: RTL
===================

Name: spike_recorder

Overview:
- Write-side counterpart of the spike-pattern ROM reader. Captures the output-neuron spike vector over each time period and stores one WIDTH-bit word per period into block RAM.
- The stored image uses the same layout as the training spike memory: word N holds the OR of all spikes seen during period N.
- Sits after the output neuron layer. Provides a registered read port for the host/bench to dump results.

Parameters:
- WIDTH, 32, spike vector width (one bit per output neuron)
- ADDR_W, 16, RAM address width; DEPTH = 2**ADDR_W words
- LOG_PERIOD, 3, log2 of cycles per time period (default period = 8 cycles; must match the `log_time_period` value in internal_defines.vh)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- en  in  1  record enable; timer and accumulator advance only when high
- spikes_in  in  WIDTH  spike vector for the current cycle
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  read address
- rd_data  out  WIDTH  read data, valid 1 cycle after rd_en
- rd_valid  out  1  high 1 cycle after rd_en
- wr_count  out  ADDR_W+1  number of words written
- period_done  out  1  1-cycle pulse when a word is committed
- full  out  1  sticky; set when wr_count == DEPTH
- overflow  out  1  sticky; set when a period completes while full

Behaviour:
- Reset (rst high at clk edge):
  - timer=0, acc=0, wr_addr=0, wr_count=0, full=0, overflow=0, period_done=0, rd_valid=0, rd_data=0.
  - RAM contents are not cleared.
- While en=1 and full=0, each cycle:
  - acc <= acc | spikes_in
  - timer <= timer+1, wrapping modulo 2**LOG_PERIOD
- On the cycle with en=1 and timer == 2**LOG_PERIOD-1 (last cycle of the period):
  - write word (acc | spikes_in) to mem[wr_addr]; this includes the current cycle's spikes.
  - acc <= 0; wr_addr <= wr_addr+1; wr_count <= wr_count+1.
  - period_done=1 on the next cycle, for one cycle.
- en=0 pauses recording: timer, acc and wr_addr hold; spikes_in is ignored. Resuming continues the same period with no loss of the accumulated bits.
- Full:
  - full asserts the cycle after the DEPTH-th write. wr_count = DEPTH, wr_addr wraps to 0 but is not used.
  - While full, no RAM writes occur and period_done is not issued.
  - Timer and acc continue to run so the period boundary stays tracked. At each completed period: overflow <= 1, acc <= 0.
  - Only rst clears full and overflow.
- Read port:
  - Synchronous, 1-cycle latency. rd_data is registered from mem[rd_addr] when rd_en=1; rd_valid follows rd_en delayed by one cycle.
  - rd_data holds its last value when rd_en=0.
  - A read and a write to the same address in the same cycle returns the old data (read-first).
- Reset mid-period discards the partial acc. No word is written for the interrupted period.
- Width rules:
  - timer is LOG_PERIOD bits with natural wrap.
  - wr_count is ADDR_W+1 bits so that DEPTH is representable.
  - acc is WIDTH bits.

Decomposition:
- The shared package/defines (internal_defines.vh) carries:
  - `log_time_period` (drives the LOG_PERIOD default)
  - spike vector width
  - memory address width
- One sub-module: spike_ram. Simple dual-port RAM (one write port, one registered read port, read-first), inferred as block RAM with attribute `ram_style = "block"`.
- Timer, accumulator, address and flag logic live in spike_recorder.

Test Plan:
- Basic capture: rst, en=1; spikes_in=32'h1 in cycle 0, 32'h80000000 in cycle 5, 0 otherwise -> period_done pulse at cycle 8; mem[0]=32'h80000001; wr_count=1.
- Last-cycle spike: spikes_in=32'h0000_0F00 only at timer=7 -> mem[0]=32'h00000F00; the following period with no spikes -> mem[1]=0.
- Pause: en=1 for 3 cycles with spikes_in=32'h2 at cycle 1, en=0 for 10 cycles (spikes_in=32'hFFFFFFFF during the pause), en=1 for 5 cycles with spikes_in=0 -> exactly one word written, mem[0]=32'h2, period_done asserted once.
- Readback: after writing 4 periods of patterns 32'hA,32'hB,32'hC,32'hD, rd_en with rd_addr=2 -> rd_valid and rd_data=32'hC next cycle. Same-address read during a write returns the previous contents.
- Full/overflow (ADDR_W=2, DEPTH=4): run 5 periods -> full=1 after the 4th write, wr_count=4, mem[0..3] intact, overflow=1 after the 5th period, no 5th period_done.
- Reset mid-operation: assert rst at timer=4 with acc nonzero -> all outputs return to reset values; the next complete period writes mem[0] containing only post-reset spikes.

Source files
------------

// File: rtl/spike_recorder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spike_recorder_pkg
// Description : Shared constants for the spike recorder slice. These values
//               track internal_defines.vh: LOG_TIME_PERIOD matches the
//               `log_time_period` define used by the rest of the network.
// Contents    : SPIKE_WIDTH     - spike vector width (one bit per neuron)
//               SPIKE_ADDR_W    - spike memory address width
//               LOG_TIME_PERIOD - log2 of cycles per time period
// Revision    : 1.0 - initial release
// ============================================================================
package spike_recorder_pkg;

  localparam int SPIKE_WIDTH     = 32;
  localparam int SPIKE_ADDR_W    = 16;
  localparam int LOG_TIME_PERIOD = 3;

endpackage : spike_recorder_pkg
`default_nettype wire

// File: rtl/spike_ram.sv
`default_nettype none
// ============================================================================
// Module      : spike_ram
// Description : Simple dual-port block RAM. One write port and one registered
//               read port. A read and a write to the same address in the same
//               cycle return the old contents (read-first). Contents are not
//               cleared by reset; only the read data register is.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               wr_en/addr/data    - write port
//               rd_en/addr         - read request
//               rd_data            - registered read data, held when rd_en=0
// Revision    : 1.0 - initial release
// ============================================================================
module spike_ram
  import spike_recorder_pkg::*;
#(
  parameter int WIDTH  = SPIKE_WIDTH,
  parameter int ADDR_W = SPIKE_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  (* ram_style = "block" *) logic [WIDTH-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Non-blocking read of mem sees the pre-write value: read-first.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule : spike_ram
`default_nettype wire

// File: rtl/spike_recorder.sv
`default_nettype none
// ============================================================================
// Module      : spike_recorder
// Description : Captures the output-neuron spike vector over each time period
//               and stores the OR of all spikes seen in period N as word N of
//               a block RAM, matching the training spike memory layout.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               en              - record enable (pauses timer/accumulator)
//               spikes_in       - spike vector for the current cycle
//               rd_en, rd_addr  - host read request
//               rd_data         - read data, 1 cycle after rd_en
//               rd_valid        - rd_en delayed by one cycle
//               wr_count        - number of words written
//               period_done     - 1-cycle pulse after a word is committed
//               full            - sticky, all DEPTH words written
//               overflow        - sticky, a period ended while full
// Revision    : 1.0 - initial release
// ============================================================================
module spike_recorder
  import spike_recorder_pkg::*;
#(
  parameter int WIDTH      = SPIKE_WIDTH,
  parameter int ADDR_W     = SPIKE_ADDR_W,
  parameter int LOG_PERIOD = LOG_TIME_PERIOD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [WIDTH-1:0]  spikes_in,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   wr_count,
  output logic              period_done,
  output logic              full,
  output logic              overflow
);

  localparam int            DEPTH      = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LAST_COUNT = (ADDR_W + 1)'(DEPTH - 1);

  logic [LOG_PERIOD-1:0] timer;
  logic [WIDTH-1:0]      acc;
  logic [ADDR_W-1:0]     wr_addr;

  logic             period_end;
  logic             wr_en;
  logic [WIDTH-1:0] merged;

  // The committed word includes the spikes of the period's last cycle.
  assign merged     = acc | spikes_in;
  assign period_end = en && (timer == '1);
  assign wr_en      = period_end && !full;

  always_ff @(posedge clk) begin
    if (rst) begin
      timer       <= '0;
      acc         <= '0;
      wr_addr     <= '0;
      wr_count    <= '0;
      full        <= 1'b0;
      overflow    <= 1'b0;
      period_done <= 1'b0;
      rd_valid    <= 1'b0;
    end else begin
      period_done <= wr_en;
      rd_valid    <= rd_en;
      if (en) begin
        // Timer keeps running while full so period boundaries stay aligned.
        timer <= timer + 1'b1;
        if (period_end) begin
          acc <= '0;
          if (full) begin
            overflow <= 1'b1;
          end else begin
            wr_addr  <= wr_addr + 1'b1;
            wr_count <= wr_count + 1'b1;
            if (wr_count == LAST_COUNT) begin
              full <= 1'b1;
            end
          end
        end else begin
          acc <= merged;
        end
      end
    end
  end

  spike_ram #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (merged),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule : spike_recorder
`default_nettype wire
